mail_sender: RTL and testbench

MAIL_SENDER -- requirements
Module: mail_sender

---
 rtl/mail_pkg.sv | 17 +
 rtl/mail_sum8.sv | 19 +
 rtl/mail_sender.sv | 176 +++++++++++++++++
 tb/tb_mail_sender.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mail_pkg.sv
// Shared constants and state encoding for the mail link sender and receiver.
package mail_pkg;

  localparam logic [7:0] START_BYTE  = 8'hAA;
  localparam logic [7:0] ADR_SINHRON = 8'h01;
  localparam int         FRAME_LEN   = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_START,
    ST_HDR_ADR,
    ST_PAYLOAD,
    ST_CRC,
    ST_FIN
  } mail_state_t;

endpackage

// File: rtl/mail_sum8.sv
// 8-bit modulo-256 byte accumulator with clear and add-enable.
module mail_sum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= 8'h00;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/mail_sender.sv
// Frame sender: START_BYTE, address, payload from a 1-cycle-latency RAM, checksum.
// Optional checksum error injection when MAIL_SENDER_ERRINJ_EN is defined.
module mail_sender #(
  parameter logic [7:0] START_BYTE  = mail_pkg::START_BYTE,
  parameter logic [7:0] ADR_DEFAULT = mail_pkg::ADR_SINHRON,
  parameter int         FRAME_LEN   = mail_pkg::FRAME_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] adr_dst,
`ifdef MAIL_SENDER_ERRINJ_EN
  input  logic       err_inj,
`endif
  output logic [7:0] pay_adr,
  input  logic [7:0] pay_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);
  import mail_pkg::*;

  localparam logic [7:0] LAST  = 8'(FRAME_LEN - 4);
  localparam logic [7:0] N_END = 8'(FRAME_LEN - 3);

  mail_state_t state;
  logic [7:0]  adr_lat;
  logic [7:0]  nxt;
  logic [7:0]  skid;
  logic        skid_v;
  logic [7:0]  fetch_adr_p1;
  logic        fetch_vld_p1;
  logic [7:0]  sum;
  logic [7:0]  crc_byte;
  logic        xfer;
  logic        accept;
  logic        avail_ram;
  logic        avail;
  logic        want_load;
  logic        load;
  logic        skid_v_nxt;
  logic [7:0]  word;
  logic [7:0]  nxt_nxt;
  logic [7:0]  adr_goal;
  logic [7:0]  adr_clamp;

  assign xfer   = tx_valid && tx_ready;
  assign accept = (state == ST_IDLE) && start && !rst;

  // pay_data always reflects the address issued one cycle earlier (fetch_adr_p1);
  // skid keeps the next needed word alive when a stall would otherwise lose it.
  assign avail_ram = fetch_vld_p1 && (fetch_adr_p1 == nxt);
  assign avail     = skid_v || avail_ram;
  assign word      = skid_v ? skid : pay_data;

  always_comb begin
    want_load = 1'b0;
    if (state == ST_HDR_ADR) begin
      want_load = xfer;
    end else if (state == ST_PAYLOAD) begin
      want_load = (xfer || !tx_valid) && (nxt != N_END);
    end
  end

  assign load       = want_load && avail;
  assign nxt_nxt    = nxt + 8'(load);
  assign skid_v_nxt = !load && avail;
  assign adr_goal   = (skid_v_nxt || (pay_adr == nxt_nxt)) ? nxt_nxt + 8'd1 : nxt_nxt;
  assign adr_clamp  = (adr_goal > LAST) ? LAST : adr_goal;

`ifdef MAIL_SENDER_ERRINJ_EN
  logic inj_lat;
  assign crc_byte = (sum + tx_data) ^ {8{inj_lat}};
`else
  assign crc_byte = sum + tx_data;
`endif

  mail_sum8 u_sum (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .add_en (xfer && (state != ST_CRC)),
    .din    (tx_data),
    .sum    (sum)
  );

  always_ff @(posedge clk) begin
    skid <= word;
    if (accept) begin
      adr_lat <= (adr_dst == 8'h00) ? ADR_DEFAULT : adr_dst;
`ifdef MAIL_SENDER_ERRINJ_EN
      inj_lat <= err_inj;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      pay_adr      <= 8'h00;
      nxt          <= 8'h00;
      skid_v       <= 1'b0;
      fetch_adr_p1 <= 8'h00;
      fetch_vld_p1 <= 1'b0;
    end else begin
      done         <= 1'b0;
      fetch_adr_p1 <= pay_adr;
      fetch_vld_p1 <= 1'b1;
      skid_v       <= skid_v_nxt;
      nxt          <= nxt_nxt;
      if (state inside {ST_HDR_START, ST_HDR_ADR, ST_PAYLOAD}) begin
        pay_adr <= adr_clamp;
      end
      if (load) begin
        tx_data  <= word;
        tx_valid <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_HDR_START;
            tx_data  <= START_BYTE;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            nxt      <= 8'h00;
            skid_v   <= 1'b0;
            pay_adr  <= 8'h00;
          end
        end
        ST_HDR_START: begin
          if (xfer) begin
            tx_data <= adr_lat;
            state   <= ST_HDR_ADR;
          end
        end
        ST_HDR_ADR: begin
          if (xfer) begin
            state <= ST_PAYLOAD;
            if (!load) tx_valid <= 1'b0;
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            if (nxt == N_END) begin
              state   <= ST_CRC;
              tx_data <= crc_byte;
            end else if (!load) begin
              tx_valid <= 1'b0;
            end
          end
        end
        ST_CRC: begin
          if (xfer) begin
            state    <= ST_FIN;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mail_sender.sv
// Directed bench for mail_sender: frame content, checksum, stalls, reset abort, ignored start.
module tb_mail_sender;
  import mail_pkg::*;

  localparam int LAST = FRAME_LEN - 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] adr_dst;
  logic [7:0] pay_adr;
  logic [7:0] pay_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       inj;

  logic [7:0] ram [256];
  logic [7:0] rx [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         adr_bad  = 0;
  bit         rnd_ready = 1'b0;
  bit         stalled = 1'b0;
  logic [7:0] held = 8'h00;

  mail_sender dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .adr_dst  (adr_dst),
`ifdef MAIL_SENDER_ERRINJ_EN
    .err_inj  (inj),
`endif
    .pay_adr  (pay_adr),
    .pay_data (pay_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pay_data <= ram[pay_adr];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // One clock: drive tx_ready for the coming edge, then observe the link.
  task automatic step();
    @(negedge clk);
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stalled) begin
      check_eq("stall_valid", 32'(tx_valid), 32'd1);
      check_eq("stall_data", 32'(tx_data), 32'(held));
    end
    stalled = tx_valid && !tx_ready && !rst;
    held    = tx_data;
    if (tx_valid && tx_ready && !rst) rx.push_back(tx_data);
    if (done) done_cnt++;
    if (busy && (pay_adr > 8'(LAST))) adr_bad++;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      ram[i] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'h01 : 8'(i);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] adr, input bit rnd,
                           input logic [7:0] crc_hand, input int poke_at);
    int         done_at;
    int         bad;
    bit         poked;
    logic [7:0] exp_q [$];
    logic [7:0] s;
    rx.delete();
    done_cnt  = 0;
    adr_bad   = 0;
    rnd_ready = rnd;
    done_at   = 0;
    poked     = 1'b0;
    adr_dst   = adr;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 2; k <= 4000 && done_at == 0; k++) begin
      if (poke_at > 0 && !poked && rx.size() == poke_at) begin
        poked   = 1'b1;
        adr_dst = 8'h77;
        start   = 1'b1;
      end
      step();
      start = 1'b0;
      if (done) done_at = k;
    end
    if (done_at == 0) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (!rnd) check_eq({tag, "_done_cycle"}, 32'(done_at), 32'(FRAME_LEN + 1));
    end
    rnd_ready = 1'b0;
    step();
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);

    exp_q.push_back(8'hAA);
    exp_q.push_back((adr == 8'h00) ? 8'h01 : adr);
    for (int i = 0; i <= LAST; i++) exp_q.push_back(ram[i]);
    s = 8'h00;
    foreach (exp_q[i]) s = s + exp_q[i];
    exp_q.push_back(s ^ {8{inj}});
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= rx.size() || rx[i] !== exp_q[i]) bad++;
    end
    check_eq({tag, "_len"}, 32'(rx.size()), 32'(FRAME_LEN));
    check_eq({tag, "_bytes_bad"}, 32'(bad), 32'd0);
    check_eq({tag, "_crc"}, 32'((rx.size() > 0) ? rx[rx.size() - 1] : 8'hxx), 32'(crc_hand));
    check_eq({tag, "_adr_range"}, 32'(adr_bad), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    adr_dst  = 8'h00;
    tx_ready = 1'b1;
    inj      = 1'b0;
    fill(0);
    step();
    step();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_pay_adr", 32'(pay_adr), 32'd0);
    rst = 1'b0;
    step();

    fill(0);
    run_frame("zero", 8'h01, 1'b0, 8'hAB, 0);
    fill(2);
    run_frame("incr", 8'h01, 1'b0, 8'h35, 0);
    fill(1);
    run_frame("ones_rnd", 8'h01, 1'b1, 8'hA7, 0);
    fill(2);
    run_frame("adr0_rnd", 8'h00, 1'b1, 8'h35, 0);

    // Abort mid-frame with reset at byte 100.
    fill(1);
    rx.delete();
    done_cnt = 0;
    adr_dst  = 8'h01;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 400 && rx.size() < 100; k++) step();
    check_eq("abort_reached", 32'(rx.size()), 32'd100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_idle_valid", 32'(tx_valid), 32'd0);
    fill(0);
    run_frame("post_abort", 8'h01, 1'b0, 8'hAB, 0);

    fill(2);
    run_frame("poke", 8'h01, 1'b0, 8'h35, 50);

    // start and rst together: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check_eq("rst_start_busy", 32'(busy), 32'd0);
    check_eq("rst_start_valid", 32'(tx_valid), 32'd0);
    step();
    check_eq("rst_start_busy2", 32'(busy), 32'd0);
    check_eq("rst_start_valid2", 32'(tx_valid), 32'd0);

`ifdef MAIL_SENDER_ERRINJ_EN
    fill(0);
    inj = 1'b1;
    run_frame("errinj", 8'h01, 1'b0, 8'h54, 0);
    inj = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
